// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshaking on both sides, a 2-entry
// skid buffer for full throughput and a synchronous flush for squashing.
module pipe_stage_reg #(
  parameter int             N       = 32,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_data_o,
  output logic [1:0]   count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         in_ready_q, out_valid_q;
  logic [1:0]   count_q;
  logic         in_ready_d, out_valid_d;
  logic [1:0]   count_d;
  logic [N-1:0] main_q, skid_q;

  logic push, pop;
  logic load_main_in, load_main_skid, load_skid;

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_q & out_ready_i;

  // Next-state and data-path steering. A flush overrides every transfer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output flags are precomputed from the next state so every output is a flop.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    count_d     = 2'd0;
    unique case (state_d)
      ONE: begin
        out_valid_d = 1'b1;
        count_d     = 2'd1;
      end
      FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        count_d     = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  // NOTE: payload registers are reset because RST_VAL is architecturally visible on out_data_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RST_VAL;
    end else if (flush_i) begin
      main_q <= RST_VAL;
    end else if (load_main_in) begin
      main_q <= in_data_i;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= RST_VAL;
    end else if (flush_i) begin
      skid_q <= RST_VAL;
    end else if (load_skid) begin
      skid_q <= in_data_i;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign count_o     = count_q;

endmodule
